// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: store lane placement, load extraction, req/ack FSM.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic              o_misaligned,
  output logic              o_bus_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_be,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_done;
  logic              r_mis;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_be;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_lane;
  logic [DATA_W-1:0] r_rdata;

  logic              w_access;
  logic              w_misaligned;
  logic              w_start;
  logic [DATA_W-1:0] w_wdata;
  logic [3:0]        w_be;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
`endif

  assign w_access = i_valid & (i_mem_read | i_mem_write);

  assign w_misaligned =
    ((i_size == 2'b01) & i_addr[0]) |
    (i_size[1] & (|i_addr[1:0]));

  assign w_start = (r_state == S_IDLE) & w_access & ~w_misaligned;

  assign o_stall      = w_start | (r_state == S_BUSY);
  assign o_done       = r_done;
  assign o_misaligned = r_mis;
  assign o_rdata      = r_rdata;
  assign o_mem_req    = r_req;
  assign o_mem_we     = r_we;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_mem_be     = r_be;

`ifdef MEM_TIMEOUT_EN
  assign o_bus_err = r_err;
`else
  assign o_bus_err = 1'b0;
`endif

  // Replicate store data across lanes and pick byte enables
  always_comb begin
    w_wdata = i_wdata;
    w_be    = 4'b1111;
    case (i_size)
      2'b00: begin
        w_wdata = {4{i_wdata[7:0]}};
        w_be    = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{i_wdata[15:0]}};
        w_be    = 4'b0011 << {i_addr[1], 1'b0};
      end
      default: begin
        w_wdata = i_wdata;
        w_be    = 4'b1111;
      end
    endcase
  end

  // Extract the addressed lane from the read word and extend it
  always_comb begin
    w_byte = i_mem_rdata[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    w_ext  = i_mem_rdata;
    case (r_size)
      2'b00:   w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_ext = i_mem_rdata;
    endcase
  end

  // Access FSM with registered bus outputs and status pulses
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 4'b0000;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_lane  <= 2'b00;
      r_rdata <= '0;
`ifdef MEM_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_mis  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_access & w_misaligned) begin
            r_mis <= 1'b1;
          end else if (w_access) begin
            r_state <= S_BUSY;
            r_req   <= 1'b1;
            r_we    <= ~i_mem_read;
            r_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_size  <= i_size;
            r_uns   <= i_unsigned;
            r_lane  <= i_addr[1:0];
`ifdef MEM_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (i_mem_ack) begin
            r_req   <= 1'b0;
            r_state <= S_RESP;
            r_done  <= 1'b1;
            if (!r_we) r_rdata <= w_ext;
`ifdef MEM_TIMEOUT_EN
          end else if (r_cnt == CNT_MAX) begin
            r_req   <= 1'b0;
            r_state <= S_RESP;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
